multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-style sequencer that converts the single-cycle MIPS datapath into a multi-cycle one with a shared instruction/data memory port. Supports R-type, lw, sw, beq, addi and j. Drives the datapath enables, mux selects and ALUOp; the ALUOp output feeds the existing ALU control decoder. Adds a memory-ready handshake, a memory timeout, fault reporting and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory state may wait for mem_ready; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clock  in  1  system clock; all state updates on the falling edge, matching the datapath registers
reset  in  1  asynchronous, active-high
op  in  6  IR[31:26] from the instruction register
mem_ready  in  1  memory has completed the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU Zero (beq)
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut reg
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  write-back select: 0 ALUOut, 1 MDR
reg_write  out  1  register file write enable
reg_dst  out  1  write-register select: 0 rt, 1 rd
alu_src_a  out  1  ALU A select: 0 PC, 1 A reg
alu_src_b  out  2  00 B reg, 01 const 4, 10 sign-ext, 11 sign-ext<<2
alu_op  out  2  00 add, 01 sub, 10 funct decode
pc_source  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
fault  out  1  sticky fault indicator
fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
retired  out  CNT_W  instructions completed since reset
state_dbg  out  4  current state encoding

Behaviour:
- Reset (async): state=START, wait counter=0, retired=0, fault=0, fault_code=00. All control outputs are decoded from state and are 0 in START.
- START: all outputs 0; goes to FETCH on the next falling edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready=1, otherwise stays.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by op:
  - 000000 goes to RTYPE_EX.
  - 100011 and 101011 go to MEMADR.
  - 000100 goes to BEQ.
  - 001000 goes to ADDI_EX.
  - 000010 goes to JUMP.
  - Any other op goes to FAULT with fault_code=01.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Goes to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Goes to FETCH on mem_ready.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Then RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- FAULT: all control outputs 0; fault=1; stays until reset.
- Latencies in falling-edge cycles, zero-wait memory:
  - R-type and addi: 4.
  - beq and j: 3.
  - sw: 4.
  - lw: 5.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT while mem_ready=0, goes to FAULT with fault_code=10.
  - mem_ready=1 in the same cycle takes priority over the timeout.
- Retired counter:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR (on ready), RTYPE_WB, ADDI_WB, BEQ or JUMP.
  - Wraps modulo 2^CNT_W.
  - Never increments in FAULT.
- Reset asserted mid-instruction aborts it immediately: outputs drop to 0 asynchronously and retired clears.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Decomposition:
- Shared package holds the following constants:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - State encodings (4-bit).
  - alu_src_b, alu_op and pc_source codes.
  - fault_code values.
- One sub-module, mem_wait_timer: wait counter and timeout compare, with inputs waiting and clear and output expired.
- FSM and output decode stay in multicycle_control.

Test Plan:
- Reset then addi $t1,$0,15 (op 001000), mem_ready=1 always: state_dbg sequence START, FETCH, DECODE, ADDI_EX, ADDI_WB, FETCH. reg_write=1 only in ADDI_WB; retired=1.
- Program addi, addi, and, sub, or, slt, slt (0x2009000f..0x014b482a) with a datapath model: final $t1=0, $t2=15, $t3=7; retired=7 after 28 cycles.
- lw with mem_ready held low 3 cycles in MEMRD: stays in MEMRD for 4 cycles, with mem_read=1 and i_or_d=1 throughout; then MEMWB with mem_to_reg=1; total 8 cycles.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: FAULT after 4 wait cycles with fault=1 and fault_code=10. No further pc_write. retired is unchanged.
- op=111111 fetched: DECODE goes to FAULT with fault_code=01. Reset then clears fault and returns via START to FETCH.
- beq with Zero=1 and j: pc_write_cond=1 with pc_source=01 in BEQ; pc_write=1 with pc_source=10 in JUMP; 3 cycles each. Assert reset during JUMP: all outputs 0 immediately, retired=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS control sequencer:
// opcodes, state encodings and datapath select codes.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BEQ      = 4'd11,
        S_JUMP     = 4'd12,
        S_FAULT    = 4'd13
    } state_e;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    // States that hold the memory port and wait for mem_ready
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// enables, selects and status out.
interface multicycle_control_if #(parameter int CNT_W = 32);

    logic [5:0]       op;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
        output ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
        output alu_src_b, alu_op, pc_source, fault, fault_code,
        output retired, state_dbg
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
        input  ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
        input  alu_src_b, alu_op, pc_source, fault, fault_code,
        input  retired, state_dbg
    );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle on which
// the wait budget runs out; MEM_TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (waiting && cnt_q != LIMIT)
            cnt_d = cnt_q + W'(1);
    end

    // This wait cycle is the one that brings the count to the limit
    assign expired = (MEM_TIMEOUT != 0) && waiting && (cnt_q == LAST);

    always_ff @(negedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath with a shared
// memory port, wait timeout, sticky fault and retired counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e           state_q, state_d;
    logic             fault_q, fault_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             waiting, expired, state_chg, retire;

    assign waiting   = is_mem_state(state_q) && !bus.mem_ready;
    assign state_chg = (state_d != state_q);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .waiting (waiting),
        .clear   (state_chg),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        unique case (state_q)
            S_START:    state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FAULT;
                        fcode_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_JUMP:
                        state_d = S_FETCH;
            default:    state_d = S_FAULT;
        endcase
        if (expired) begin
            state_d = S_FAULT;
            fcode_d = FC_TIMEOUT;
        end
        fault_d = fault_q || (state_d == S_FAULT);
    end

    // Any return to FETCH other than the boot step completes an instruction
    assign retire    = (state_d == S_FETCH) &&
                       (state_q != S_START) && (state_q != S_FETCH);
    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_START;
            fault_q   <= 1'b0;
            fcode_q   <= FC_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            fcode_q   <= fcode_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCS_ALU;
        unique case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_4;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = SRCB_BR;
            S_MEMADR, S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_RTYPE_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_ADDI_WB:  bus.reg_write = 1'b1;
            S_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCS_OUT;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_JMP;
            end
            default: ;
        endcase
    end

    assign bus.fault      = fault_q;
    assign bus.fault_code = fcode_q;
    assign bus.retired    = retired_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a scoreboard queue and a
// small multi-cycle datapath model for the program run.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CNT_W = 32;
    localparam int TMO   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] op_drv;
    logic       rdy_drv;
    logic       dp_mode;

    always #5 clock = ~clock;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // datapath model
    logic [31:0] mem [0:63];
    logic [31:0] rf  [0:31];
    logic [31:0] pc, ir, a_r, b_r, aluout, mdr;
    logic [31:0] srca, srcb, alu_y, simm, madr, mword;
    logic [4:0]  wreg;

    assign bus.op        = dp_mode ? ir[31:26] : op_drv;
    assign bus.mem_ready = rdy_drv;

    always_comb begin
        simm  = {{16{ir[15]}}, ir[15:0]};
        srca  = bus.alu_src_a ? a_r : pc;
        case (bus.alu_src_b)
            2'b00:   srcb = b_r;
            2'b01:   srcb = 32'd4;
            2'b10:   srcb = simm;
            default: srcb = simm << 2;
        endcase
        alu_y = srca + srcb;
        if (bus.alu_op == 2'b01)
            alu_y = srca - srcb;
        else if (bus.alu_op == 2'b10) begin
            case (ir[5:0])
                6'h22:   alu_y = srca - srcb;
                6'h24:   alu_y = srca & srcb;
                6'h25:   alu_y = srca | srcb;
                6'h2a:   alu_y = {31'b0, $signed(srca) < $signed(srcb)};
                default: alu_y = srca + srcb;
            endcase
        end
        madr  = bus.i_or_d ? aluout : pc;
        mword = mem[madr[7:2]];
        wreg  = bus.reg_dst ? ir[15:11] : ir[20:16];
    end

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            pc <= 0; ir <= 0; a_r <= 0; b_r <= 0; aluout <= 0; mdr <= 0;
            for (int i = 0; i < 32; i++) rf[i] <= 0;
        end else begin
            if (bus.ir_write) ir <= mword;
            mdr    <= mword;
            a_r    <= rf[ir[25:21]];
            b_r    <= rf[ir[20:16]];
            aluout <= alu_y;
            if (bus.reg_write && wreg != 0)
                rf[wreg] <= bus.mem_to_reg ? mdr : aluout;
            if (bus.pc_write || (bus.pc_write_cond && alu_y == 0)) begin
                case (bus.pc_source)
                    2'b00:   pc <= alu_y;
                    2'b01:   pc <= aluout;
                    default: pc <= {pc[31:28], ir[25:0], 2'b00};
                endcase
            end
        end
    end

    // scoreboard
    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  compared   = 0;
    int  mismatched = 0;

    logic [15:0] ctrl_obs;
    assign ctrl_obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d,
                       bus.mem_read, bus.mem_write, bus.ir_write,
                       bus.mem_to_reg, bus.reg_write, bus.reg_dst,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.pc_source};

    function automatic logic [15:0] exp_ctrl(state_e s, logic r);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0;
        logic irw = 0, mtr = 0, rw = 0, rd = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, pcs = 0;
        case (s)
            S_FETCH:    begin mr = 1; asb = 2'b01; pw = r; irw = r; end
            S_DECODE:   asb = 2'b11;
            S_MEMADR:   begin asa = 1; asb = 2'b10; end
            S_MEMRD:    begin mr = 1; iod = 1; end
            S_MEMWB:    begin rw = 1; mtr = 1; end
            S_MEMWR:    begin mw = 1; iod = 1; end
            S_RTYPE_EX: begin asa = 1; aop = 2'b10; end
            S_RTYPE_WB: begin rw = 1; rd = 1; end
            S_ADDI_EX:  begin asa = 1; asb = 2'b10; end
            S_ADDI_WB:  rw = 1;
            S_BEQ:      begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            S_JUMP:     begin pw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, mtr, rw, rd, asa, asb, aop, pcs};
    endfunction

    task automatic push(input string t, input logic [63:0] e);
        sbq.push_back('{t, e});
    endtask

    task automatic pop_cmp(input logic [63:0] act);
        sb_t s;
        if (sbq.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed %0h with nothing expected", act);
            return;
        end
        s = sbq.pop_front();
        compared++;
        assert (act === s.exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", s.tag, act, s.exp);
        end
    endtask

    task automatic check(input string t, input logic [63:0] act,
                         input logic [63:0] e);
        push(t, e);
        pop_cmp(act);
    endtask

    // One falling-edge cycle: compare at the rising edge, advance on the fall
    task automatic step(input logic [5:0] o, input logic r, input state_e es);
        op_drv  = o;
        rdy_drv = r;
        push($sformatf("state@%s", es.name()), 64'(es));
        push($sformatf("ctrl@%s", es.name()), 64'(exp_ctrl(es, r)));
        @(posedge clock);
        pop_cmp(64'(bus.state_dbg));
        pop_cmp(64'(ctrl_obs));
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rdy_drv = 1'b1;
        @(posedge clock);
        check("rst_state", 64'(bus.state_dbg), 64'(S_START));
        check("rst_ctrl", 64'(ctrl_obs), 64'd0);
        check("rst_retired", 64'(bus.retired), 64'd0);
        check("rst_fault", 64'({bus.fault, bus.fault_code}), 64'd0);
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        dp_mode = 1'b0;
        op_drv  = OP_ADDI;
        rdy_drv = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0] = 32'h2009000f;
        mem[1] = 32'h200a0007;
        mem[2] = 32'h012a5824;
        mem[3] = 32'h012a5022;
        mem[4] = 32'h014b5025;
        mem[5] = 32'h016a482a;
        mem[6] = 32'h014b482a;
        @(negedge clock);
        #1;
        do_reset();

        // addi with zero-wait memory
        step(OP_ADDI, 1'b1, S_START);
        step(OP_ADDI, 1'b1, S_FETCH);
        step(OP_ADDI, 1'b1, S_DECODE);
        step(OP_ADDI, 1'b1, S_ADDI_EX);
        step(OP_ADDI, 1'b1, S_ADDI_WB);
        check("addi_state", 64'(bus.state_dbg), 64'(S_FETCH));
        check("addi_retired", 64'(bus.retired), 64'd1);

        // fetch timeout after TMO wait cycles
        for (int i = 0; i < TMO; i++) step(OP_ADDI, 1'b0, S_FETCH);
        step(OP_ADDI, 1'b0, S_FAULT);
        check("tmo_fault", 64'(bus.fault), 64'd1);
        check("tmo_code", 64'(bus.fault_code), 64'(FC_TIMEOUT));
        step(OP_ADDI, 1'b1, S_FAULT);
        step(OP_ADDI, 1'b1, S_FAULT);
        check("tmo_retired", 64'(bus.retired), 64'd1);

        // illegal opcode
        do_reset();
        step(6'h3f, 1'b1, S_START);
        step(6'h3f, 1'b1, S_FETCH);
        step(6'h3f, 1'b1, S_DECODE);
        step(6'h3f, 1'b1, S_FAULT);
        check("ill_fault", 64'(bus.fault), 64'd1);
        check("ill_code", 64'(bus.fault_code), 64'(FC_ILLEGAL));
        check("ill_retired", 64'(bus.retired), 64'd0);
        do_reset();

        // beq then j, reset during JUMP
        step(OP_BEQ, 1'b1, S_START);
        step(OP_BEQ, 1'b1, S_FETCH);
        step(OP_BEQ, 1'b1, S_DECODE);
        step(OP_BEQ, 1'b1, S_BEQ);
        check("beq_retired", 64'(bus.retired), 64'd1);
        step(OP_J, 1'b1, S_FETCH);
        step(OP_J, 1'b1, S_DECODE);
        push("state@JUMP", 64'(S_JUMP));
        push("ctrl@JUMP", 64'(exp_ctrl(S_JUMP, 1'b1)));
        push("j_retired_pre", 64'd1);
        @(posedge clock);
        pop_cmp(64'(bus.state_dbg));
        pop_cmp(64'(ctrl_obs));
        pop_cmp(64'(bus.retired));
        #1;
        reset = 1'b1;
        #1;
        check("abort_state", 64'(bus.state_dbg), 64'(S_START));
        check("abort_ctrl", 64'(ctrl_obs), 64'd0);
        check("abort_retired", 64'(bus.retired), 64'd0);
        @(negedge clock);
        #1;
        reset = 1'b0;

        // lw with three wait cycles, then sw
        step(OP_LW, 1'b1, S_START);
        step(OP_LW, 1'b1, S_FETCH);
        step(OP_LW, 1'b1, S_DECODE);
        step(OP_LW, 1'b1, S_MEMADR);
        for (int i = 0; i < 3; i++) step(OP_LW, 1'b0, S_MEMRD);
        step(OP_LW, 1'b1, S_MEMRD);
        step(OP_LW, 1'b1, S_MEMWB);
        check("lw_state", 64'(bus.state_dbg), 64'(S_FETCH));
        check("lw_retired", 64'(bus.retired), 64'd1);
        step(OP_SW, 1'b1, S_FETCH);
        step(OP_SW, 1'b1, S_DECODE);
        step(OP_SW, 1'b1, S_MEMADR);
        step(OP_SW, 1'b1, S_MEMWR);
        check("sw_retired", 64'(bus.retired), 64'd2);

        // seven-instruction program through the datapath model
        dp_mode = 1'b1;
        do_reset();
        push("prog_t1", 64'd0);
        push("prog_t2", 64'd15);
        push("prog_t3", 64'd7);
        push("prog_retired", 64'd7);
        push("prog_state", 64'(S_FETCH));
        repeat (29) @(negedge clock);
        #1;
        pop_cmp(64'(rf[9]));
        pop_cmp(64'(rf[10]));
        pop_cmp(64'(rf[11]));
        pop_cmp(64'(bus.retired));
        pop_cmp(64'(bus.state_dbg));
        dp_mode = 1'b0;

        if (sbq.size() != 0) begin
            mismatched++;
            $error("FAIL sb_leftover: observed %0d entries expected 0",
                   sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
